// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and transmitter state encoding
package uart_pkg;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_STOP_BITS  = 1;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_START, ST_DATA, ST_STOP} uart_state_e;
endpackage

// File: rtl/uart_rise_detect.sv
// rise_detect: one-cycle pulse on each rising edge of a clk-synchronous level
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);
    logic level_q;
    // Delay the level one cycle; reset high so a level already high at release is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) level_q <= 1'b1;
        else        level_q <= level_i;
    end
    assign rise_o = level_i & ~level_q;
endmodule

// File: rtl/uart_tx_baud.sv
// uart_tx_baud: valid/ready serial transmitter stepping one bit per baud reference rise
module uart_tx_baud
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int STOP_BITS = UART_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 frame_done
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d, bit_nxt;
    logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 frame_done_q, frame_done_d;
    logic                 tick, accept;

    rise_detect u_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (baud_clk),
        .rise_o  (tick)
    );

    assign accept  = tx_valid & tx_ready_q & (state_q == ST_IDLE);
    assign bit_nxt = bit_idx_q + BW'(1);

    // State and datapath registers; reset abandons any frame in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= '0;
            tx_out_q     <= UART_IDLE_LEVEL;
            tx_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_out_q     <= tx_out_d;
            tx_ready_q   <= tx_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: IDLE moves on acceptance only, every other state advances on a tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SYNC;
            ST_SYNC:  if (tick) state_d = ST_START;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA:  if (tick && bit_idx_q == BIT_LAST) state_d = ST_STOP;
            ST_STOP:  if (tick && stop_cnt_q == STOP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs and counters: line level changes only on the tick that advances the frame
    always_comb begin
        data_d       = accept ? tx_data : data_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        tx_out_d     = tx_out_q;
        tx_ready_d   = (state_d == ST_IDLE);
        frame_done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        if (tick) begin
            case (state_q)
                ST_SYNC:  tx_out_d = 1'b0;
                ST_START: begin
                    tx_out_d  = data_q[0];
                    bit_idx_d = '0;
                end
                ST_DATA: begin
                    if (bit_idx_q == BIT_LAST) begin
                        tx_out_d   = UART_IDLE_LEVEL;
                        stop_cnt_d = '0;
                    end else begin
                        bit_idx_d = bit_nxt;
                        tx_out_d  = data_q[bit_nxt];
                    end
                end
                ST_STOP:  if (stop_cnt_q != STOP_LAST) stop_cnt_d = stop_cnt_q + SW'(1);
                default:  ;
            endcase
        end
    end

    assign tx_out     = tx_out_q;
    assign tx_ready   = tx_ready_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_uart_tx_baud.sv
// tb_uart_tx_baud: directed and randomized checks of two transmitter configurations against a frame-queue model
module tb_uart_tx_baud;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] div_q = 2'd0;
    logic       baud_clk;
    logic [1:0] valid = 2'b00;
    logic [7:0] data = 8'h00;
    logic [1:0] t_out, t_rdy, t_done;
    int passed = 0, fails = 0, total = 0;
    int db[2] = '{8, 7};
    int sb[2] = '{1, 2};
    logic e_out[2], e_rdy[2], e_done[2], busy[2];
    logic fr[2][12];
    int   flen[2], fpos[2];
    logic prev = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) div_q <= div_q + 2'd1;
    assign baud_clk = div_q[1];

    uart_tx_baud #(.DATA_BITS(8), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_valid(valid[0]), .tx_data(data),
        .tx_ready(t_rdy[0]), .tx_out(t_out[0]), .frame_done(t_done[0]));
    uart_tx_baud #(.DATA_BITS(7), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_valid(valid[1]), .tx_data(data[6:0]),
        .tx_ready(t_rdy[1]), .tx_out(t_out[1]), .frame_done(t_done[1]));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // The line is a queue of levels: each tick after acceptance pops one, the tick after the last ends the frame
    task automatic step(int k, logic tk);
        if (!rst_n) begin
            e_out[k] = 1'b1; e_rdy[k] = 1'b0; e_done[k] = 1'b0; busy[k] = 1'b0;
        end else begin
            e_done[k] = 1'b0;
            if (!busy[k]) begin
                if (valid[k] && e_rdy[k]) begin
                    flen[k] = 1 + db[k] + sb[k]; fpos[k] = 0; busy[k] = 1'b1; e_rdy[k] = 1'b0;
                    for (int i = 0; i < 12; i++) fr[k][i] = (i == 0) ? 1'b0 : (i <= db[k]) ? data[i-1] : 1'b1;
                end else e_rdy[k] = 1'b1;
            end else if (tk) begin
                if (fpos[k] < flen[k]) begin
                    e_out[k] = fr[k][fpos[k]];
                    fpos[k]++;
                end else begin
                    busy[k] = 1'b0; e_done[k] = 1'b1; e_rdy[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc();
        logic tk;
        @(posedge clk);
        tk = rst_n && baud_clk && !prev;
        prev = rst_n ? baud_clk : 1'b1;
        for (int k = 0; k < 2; k++) step(k, tk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("tx_out%0d", k), 32'(t_out[k]), 32'(e_out[k]));
            chk($sformatf("tx_ready%0d", k), 32'(t_rdy[k]), 32'(e_rdy[k]));
            chk($sformatf("frame_done%0d", k), 32'(t_done[k]), 32'(e_done[k]));
        end
    endtask

    task automatic launch(int k, logic [7:0] d);
        logic acc = 1'b0;
        data = d;
        valid[k] = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = e_rdy[k];
            cyc();
        end
        valid[k] = 1'b0;
        chk("accept_timeout", 32'(acc), 32'd1);
        for (int i = 0; i < 12 && t_out[k] !== 1'b0; i++) cyc();
        chk("start_timeout", 32'(t_out[k]), 32'd0);
    endtask

    task automatic frame(int k, logic [7:0] d, logic poke);
        logic [11:0] bits;
        int n, t;
        n = 1 + db[k] + sb[k];
        for (int i = 0; i < 12; i++) bits[i] = (i == 0) ? 1'b0 : (i <= db[k]) ? d[i-1] : 1'b1;
        launch(k, d);
        t = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < ((i == 0) ? 2 : 4); j++) begin
                valid[k] = poke && i == 3 && j == 0;
                if (valid[k]) data = ~d;
                cyc();
                t++;
            end
            chk($sformatf("bit%0d_%0d", k, i), 32'(t_out[k]), 32'(bits[i]));
        end
        valid[k] = 1'b0;
        while (t_done[k] !== 1'b1 && t < 80) begin
            cyc();
            t++;
        end
        chk("frame_len", 32'(t), 32'(4 * n));
        chk("ready_at_done", 32'(t_rdy[k]), 32'd1);
        cyc();
        chk("done_one_cycle", 32'(t_done[k]), 32'd0);
    endtask

    initial begin
        int t, acc, pulses;
        repeat (3) cyc();
        chk("rst_out", 32'(t_out[0]), 32'd1);
        chk("rst_ready", 32'(t_rdy[0]), 32'd0);
        chk("rst_done", 32'(t_done[0]), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("ready_after_rst", 32'(t_rdy[0]), 32'd1);
        repeat (5) cyc();
        frame(0, 8'hA5, 1'b1);
        repeat (12) cyc();
        frame(1, 8'h55, 1'b0);
        repeat (3) cyc();
        // accept in the very cycle the baud reference rises
        for (int i = 0; i < 8 && div_q != 2'd2; i++) cyc();
        valid[0] = 1'b1;
        data = 8'(($urandom));
        cyc();
        valid[0] = 1'b0;
        chk("ready_drop", 32'(t_rdy[0]), 32'd0);
        t = 0;
        while (t_out[0] !== 1'b0 && t < 12) begin
            cyc();
            t++;
        end
        chk("sync_latency", 32'(t), 32'd4);
        for (int i = 0; i < 60 && t_rdy[0] !== 1'b1; i++) cyc();
        cyc();
        // back-to-back frames with valid held high
        valid[0] = 1'b1;
        data = 8'h00;
        acc = 0;
        pulses = 0;
        for (int i = 0; i < 200 && pulses < 2; i++) begin
            if (e_rdy[0] && valid[0]) acc++;
            cyc();
            if (acc == 1) data = 8'hFF;
            if (acc == 2) valid[0] = 1'b0;
            if (t_done[0] === 1'b1) pulses++;
        end
        valid[0] = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd2);
        chk("b2b_done", 32'(pulses), 32'd2);
        repeat (4) cyc();
        // reset during data bit 3 of 0x3C
        launch(0, 8'h3C);
        repeat (18) cyc();
        chk("bit3_before_rst", 32'(t_out[0]), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("midrst_out", 32'(t_out[0]), 32'd1);
        chk("midrst_ready", 32'(t_rdy[0]), 32'd0);
        chk("midrst_done", 32'(t_done[0]), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        frame(0, 8'h81, 1'b0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            valid[0] = ($urandom_range(0, 3) == 0);
            valid[1] = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            cyc();
        end
        valid = 2'b00;
        rst_n = 1'b1;
        repeat (100) cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
